// File: rtl/p2s_serializer.sv
// p2s_serializer: parallel-to-serial shifter with valid/ready word load.
//
// A WIDTH-bit word is accepted over a load_valid/load_ready handshake and
// shifted out one bit per shift_en strobe, MSB- or LSB-first. The next word
// can be accepted in the same cycle the final bit is consumed, so
// back-to-back frames run without a gap.
//
// Ports:
//   Clock       in   rising-edge clock
//   rst         in   asynchronous reset, active-high
//   data        in   parallel word to serialise
//   load_valid  in   data is valid this cycle
//   load_ready  out  block accepts data this cycle
//   shift_en    in   bit strobe; the current bit is consumed when 1
//   sIn         in   fill bit shifted in at the vacated end
//   sOut        out  current serial bit
//   sOut_valid  out  sOut holds a frame bit
//   last        out  sOut is the final bit of the frame
//   busy        out  a frame is in progress
//   done        out  one-cycle pulse after the final bit is consumed
module p2s_serializer #(
    parameter int unsigned WIDTH     = 10,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    input  logic             sIn,
    output logic             sOut,
    output logic             sOut_valid,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned          CntW   = $clog2(WIDTH);
    localparam logic [CntW-1:0]      CntMax = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state;
    logic [WIDTH-1:0] shreg;
    logic [CntW-1:0]  cnt;     // remaining bits minus one
    logic             final_bit;

    // Final bit of the frame is being consumed this cycle.
    assign final_bit  = (state == StShift) && shift_en && (cnt == '0);

    assign load_ready = (state == StIdle) || final_bit;
    assign busy       = (state == StShift);
    assign sOut_valid = (state == StShift);
    assign last       = (state == StShift) && (cnt == '0);
    assign sOut       = (state == StShift) && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (load_valid) begin
                        shreg <= data;
                        cnt   <= CntMax;
                        state <= StShift;
                    end
                end
                StShift: begin
                    if (shift_en) begin
                        if (cnt == '0) begin
                            done <= 1'b1;
                            // Reload in the same cycle keeps back-to-back frames contiguous.
                            if (load_valid) begin
                                shreg <= data;
                                cnt   <= CntMax;
                            end else begin
                                state <= StIdle;
                            end
                        end else begin
                            if (MSB_FIRST) begin
                                shreg <= {shreg[WIDTH-2:0], sIn};
                            end else begin
                                shreg <= {sIn, shreg[WIDTH-1:1]};
                            end
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
